// File: rtl/dtcm_dual_port.sv
// rtl/dtcm_dual_port.sv - two request channels arbitrated onto one single-port data TCM array
// Each channel owns a one-entry response buffer; a full, undrained buffer blocks that channel's grant.
module dtcm_dual_port #(
  parameter int DP       = 1024,
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int ARB_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            c0_req_valid,
  output logic            c0_req_ready,
  input  logic            c0_req_wr,
  input  logic [DW/8-1:0] c0_req_be,
  input  logic [AW-1:0]   c0_req_addr,
  input  logic [DW-1:0]   c0_req_wdata,
  output logic            c0_rsp_valid,
  input  logic            c0_rsp_ready,
  output logic [DW-1:0]   c0_rsp_rdata,
  output logic            c0_rsp_err,

  input  logic            c1_req_valid,
  output logic            c1_req_ready,
  input  logic            c1_req_wr,
  input  logic [DW/8-1:0] c1_req_be,
  input  logic [AW-1:0]   c1_req_addr,
  input  logic [DW-1:0]   c1_req_wdata,
  output logic            c1_rsp_valid,
  input  logic            c1_rsp_ready,
  output logic [DW-1:0]   c1_rsp_rdata,
  output logic            c1_rsp_err
);

  localparam int BW  = DW / 8;
  localparam int OFS = $clog2(BW);
  localparam int IW  = $clog2(DP);
  localparam int WAW = AW - OFS;
  localparam logic [WAW-1:0] DP_W = WAW'(DP);

  logic [DW-1:0] mem [DP];

  logic          elig0, elig1;
  logic          grant0, grant1;
  logic          rr_last;
  logic          acc;
  logic          acc_wr;
  logic [BW-1:0] acc_be;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_err;
  logic [IW-1:0] acc_idx;
  logic [DW-1:0] rsp_word;

  // rr_last holds the previous winner; the other channel wins a tie in round-robin mode.
  always_comb begin
    elig0  = c0_req_valid & (~c0_rsp_valid | c0_rsp_ready);
    elig1  = c1_req_valid & (~c1_rsp_valid | c1_rsp_ready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      if (ARB_MODE == 0 || rr_last) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign c0_req_ready = rst_n & grant0;
  assign c1_req_ready = rst_n & grant1;

  assign acc       = grant0 | grant1;
  assign acc_wr    = grant1 ? c1_req_wr    : c0_req_wr;
  assign acc_be    = grant1 ? c1_req_be    : c0_req_be;
  assign acc_addr  = grant1 ? c1_req_addr  : c0_req_addr;
  assign acc_wdata = grant1 ? c1_req_wdata : c0_req_wdata;
  assign acc_err   = (acc_addr[OFS-1:0] != '0) || (acc_addr[AW-1:OFS] >= DP_W);
  assign acc_idx   = acc_addr[OFS+IW-1:OFS];
  assign rsp_word  = (!acc_wr && !acc_err) ? mem[acc_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst_n && acc && acc_wr && !acc_err) begin
      for (int k = 0; k < BW; k++) begin
        if (acc_be[k]) begin
          mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (acc) begin
      rr_last <= grant1;
    end
  end

  // A grant refilling the slot takes precedence over the drain of the old response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c0_rsp_valid <= 1'b0;
      c0_rsp_err   <= 1'b0;
      c0_rsp_rdata <= '0;
    end else if (grant0) begin
      c0_rsp_valid <= 1'b1;
      c0_rsp_err   <= acc_err;
      c0_rsp_rdata <= rsp_word;
    end else if (c0_rsp_ready) begin
      c0_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c1_rsp_valid <= 1'b0;
      c1_rsp_err   <= 1'b0;
      c1_rsp_rdata <= '0;
    end else if (grant1) begin
      c1_rsp_valid <= 1'b1;
      c1_rsp_err   <= acc_err;
      c1_rsp_rdata <= rsp_word;
    end else if (c1_rsp_ready) begin
      c1_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dtcm_dual_port.sv
// tb/tb_dtcm_dual_port.sv - fixed-priority and round-robin instances against one behavioural model
module tb_dtcm_dual_port;

  localparam int DP = 1024;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        c0_valid, c0_wr, c0_rsp_rdy;
  logic [3:0]  c0_be;
  logic [31:0] c0_addr, c0_wdata;
  logic        c1_valid, c1_wr, c1_rsp_rdy;
  logic [3:0]  c1_be;
  logic [31:0] c1_addr, c1_wdata;

  logic [1:0]  c0_rdy, c0_rv, c0_re, c1_rdy, c1_rv, c1_re;
  logic [31:0] c0_rd [2];
  logic [31:0] c1_rd [2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    dtcm_dual_port #(.DP(DP), .DW(32), .AW(32), .ARB_MODE(d)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .c0_req_valid (c0_valid),
      .c0_req_ready (c0_rdy[d]),
      .c0_req_wr    (c0_wr),
      .c0_req_be    (c0_be),
      .c0_req_addr  (c0_addr),
      .c0_req_wdata (c0_wdata),
      .c0_rsp_valid (c0_rv[d]),
      .c0_rsp_ready (c0_rsp_rdy),
      .c0_rsp_rdata (c0_rd[d]),
      .c0_rsp_err   (c0_re[d]),
      .c1_req_valid (c1_valid),
      .c1_req_ready (c1_rdy[d]),
      .c1_req_wr    (c1_wr),
      .c1_req_be    (c1_be),
      .c1_req_addr  (c1_addr),
      .c1_req_wdata (c1_wdata),
      .c1_rsp_valid (c1_rv[d]),
      .c1_rsp_ready (c1_rsp_rdy),
      .c1_rsp_rdata (c1_rd[d]),
      .c1_rsp_err   (c1_re[d])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Model: word-granular memory per instance, response slot per channel.
  logic [31:0] m_mem [2][NW];
  bit          m_rv  [2][2];
  logic [31:0] m_rd  [2][2];
  bit          m_re  [2][2];
  bit          m_clr [2][2];
  int          m_last [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_rd(input int d, input int c);
    return (c == 0) ? c0_rd[d] : c1_rd[d];
  endfunction

  task automatic step();
    bit          v [2];
    bit          w [2];
    bit          rr [2];
    logic [3:0]  be [2];
    logic [31:0] a [2];
    logic [31:0] wd [2];
    v[0] = c0_valid;   v[1] = c1_valid;
    w[0] = c0_wr;      w[1] = c1_wr;
    rr[0] = c0_rsp_rdy; rr[1] = c1_rsp_rdy;
    be[0] = c0_be;     be[1] = c1_be;
    a[0] = c0_addr;    a[1] = c1_addr;
    wd[0] = c0_wdata;  wd[1] = c1_wdata;
    #1;
    for (int d = 0; d < 2; d++) begin
      int win;
      bit cand [2];
      for (int c = 0; c < 2; c++) cand[c] = v[c] && (!m_rv[d][c] || rr[c]);
      win = -1;
      if (cand[0] && cand[1]) win = (d == 0) ? 0 : 1 - m_last[d];
      else if (cand[0]) win = 0;
      else if (cand[1]) win = 1;

      for (int c = 0; c < 2; c++) begin
        chk($sformatf("req_ready d%0d c%0d", d, c),
            32'((c == 0) ? c0_rdy[d] : c1_rdy[d]), 32'(rst_n === 1'b1 && win == c));
        chk($sformatf("rsp_valid d%0d c%0d", d, c),
            32'((c == 0) ? c0_rv[d] : c1_rv[d]), 32'(m_rv[d][c]));
        if (m_rv[d][c] || m_clr[d][c]) begin
          chk($sformatf("rsp_rdata d%0d c%0d", d, c), dut_rd(d, c), m_rd[d][c]);
          chk($sformatf("rsp_err d%0d c%0d", d, c),
              32'((c == 0) ? c0_re[d] : c1_re[d]), 32'(m_re[d][c]));
        end
      end

      if (!rst_n) begin
        for (int c = 0; c < 2; c++) begin
          m_rv[d][c] = 0; m_rd[d][c] = '0; m_re[d][c] = 0; m_clr[d][c] = 1;
        end
        m_last[d] = 1;
      end else begin
        for (int c = 0; c < 2; c++) begin
          if (win == c) begin
            bit          e;
            int          wi;
            logic [31:0] rdv;
            e   = (a[c] % 4 != 0) || (a[c] / 4 >= DP);
            wi  = int'(a[c] / 4);
            rdv = '0;
            if (!e && wi < NW) begin
              if (w[c]) begin
                for (int k = 0; k < 4; k++)
                  if (be[c][k]) m_mem[d][wi][8*k +: 8] = wd[c][8*k +: 8];
              end else begin
                rdv = m_mem[d][wi];
              end
            end
            m_rv[d][c] = 1; m_rd[d][c] = rdv; m_re[d][c] = e; m_clr[d][c] = 0;
          end else if (rr[c]) begin
            m_rv[d][c] = 0;
          end
        end
        if (win >= 0) m_last[d] = win;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_c0(input bit v, input bit wr, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd);
    c0_valid = v; c0_wr = wr; c0_be = be; c0_addr = a; c0_wdata = wd;
  endtask

  task automatic set_c1(input bit v, input bit wr, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd);
    c1_valid = v; c1_wr = wr; c1_be = be; c1_addr = a; c1_wdata = wd;
  endtask

  task automatic chk_c0_rsp(input string name, input logic [31:0] rd, input bit err);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s valid d%0d", name, d), 32'(c0_rv[d]), 32'd1);
      chk($sformatf("%s rdata d%0d", name, d), c0_rd[d], rd);
      chk($sformatf("%s err d%0d", name, d), 32'(c0_re[d]), 32'(err));
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return (32'($urandom_range(0, NW - 1)) << 2) | 32'($urandom_range(1, 3));
    if (r == 1) return ($urandom | 32'h8000_0000) & ~32'h3;
    return 32'($urandom_range(0, NW - 1)) << 2;
  endfunction

  initial begin
    rst_n = 1'b0;
    set_c0(1, 1, 4'hF, 32'h10, 32'h5555_5555);
    set_c1(1, 1, 4'hF, 32'h14, 32'h6666_6666);
    c0_rsp_rdy = 1'b1; c1_rsp_rdy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 1;
      for (int c = 0; c < 2; c++) begin
        m_rv[d][c] = 0; m_rd[d][c] = '0; m_re[d][c] = 0; m_clr[d][c] = 0;
      end
      for (int i = 0; i < NW; i++) m_mem[d][i] = '0;
    end
    @(negedge clk);
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset c0_rsp_valid d%0d", d), 32'(c0_rv[d]), 32'd0);
      chk($sformatf("reset c1_rsp_valid d%0d", d), 32'(c1_rv[d]), 32'd0);
      chk($sformatf("reset c0_rsp_rdata d%0d", d), c0_rd[d], 32'd0);
      chk($sformatf("reset c0_req_ready d%0d", d), 32'(c0_rdy[d]), 32'd0);
    end

    rst_n = 1'b1;
    set_c1(0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < NW; i++) begin
      set_c0(1, 1, 4'hF, 32'(i * 4), $urandom);
      step();
    end

    set_c0(1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF); step();
    chk_c0_rsp("write ack", 32'h0, 0);
    set_c0(1, 0, 4'h0, 32'h10, 32'h0); step();
    chk_c0_rsp("full read", 32'hDEAD_BEEF, 0);
    set_c0(1, 1, 4'b0100, 32'h10, 32'h00AA_0000); step();
    set_c0(1, 0, 4'h0, 32'h10, 32'h0); step();
    chk_c0_rsp("partial read", 32'hDEAA_BEEF, 0);
    set_c0(1, 1, 4'h0, 32'h10, 32'hFFFF_FFFF); step();
    set_c0(1, 0, 4'h0, 32'h10, 32'h0); step();
    chk_c0_rsp("be0 read", 32'hDEAA_BEEF, 0);
    set_c0(1, 1, 4'hF, 32'h14, 32'h0BAD_F00D); step();
    set_c0(1, 0, 4'h0, 32'h3, 32'h0); step();
    chk_c0_rsp("misaligned", 32'h0, 1);
    set_c0(1, 0, 4'h0, 32'(DP * 4), 32'h0); step();
    chk_c0_rsp("out of range", 32'h0, 1);
    set_c0(1, 0, 4'h0, 32'h10, 32'h0); step();
    chk_c0_rsp("after err read", 32'hDEAA_BEEF, 0);

    set_c0(0, 0, 4'h0, 32'h0, 32'h0);
    set_c1(1, 0, 4'h0, 32'h14, 32'h0); step();
    for (int i = 0; i < 6; i++) begin
      set_c0(1, 0, 4'h0, 32'h10, 32'h0);
      set_c1(1, 0, 4'h0, 32'h14, 32'h0);
      #1;
      chk($sformatf("fixed c0 grant %0d", i), 32'(c0_rdy[0]), 32'd1);
      chk($sformatf("fixed c1 grant %0d", i), 32'(c1_rdy[0]), 32'd0);
      chk($sformatf("rr c0 grant %0d", i), 32'(c0_rdy[1]), 32'(i % 2 == 0));
      chk($sformatf("rr c1 grant %0d", i), 32'(c1_rdy[1]), 32'(i % 2 == 1));
      step();
    end

    set_c0(0, 0, 4'h0, 32'h0, 32'h0);
    set_c1(0, 0, 4'h0, 32'h0, 32'h0); step();
    set_c1(1, 0, 4'h0, 32'h10, 32'h0); c1_rsp_rdy = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("bp first grant d%0d", d), 32'(c1_rdy[d]), 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      set_c0(1, 0, 4'h0, 32'h14, 32'h0);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("bp c1 blocked d%0d", d), 32'(c1_rdy[d]), 32'd0);
        chk($sformatf("bp c0 proceeds d%0d", d), 32'(c0_rdy[d]), 32'd1);
        chk($sformatf("bp c1 held valid d%0d", d), 32'(c1_rv[d]), 32'd1);
        chk($sformatf("bp c1 held data d%0d", d), c1_rd[d], 32'hDEAA_BEEF);
      end
      step();
    end
    set_c0(0, 0, 4'h0, 32'h0, 32'h0); c1_rsp_rdy = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("bp release d%0d", d), 32'(c1_rdy[d]), 32'd1);
    step();

    set_c1(0, 0, 4'h0, 32'h0, 32'h0);
    set_c0(1, 0, 4'h0, 32'h10, 32'h0); c0_rsp_rdy = 1'b0; step();
    set_c0(0, 0, 4'h0, 32'h0, 32'h0);
    set_c1(1, 1, 4'hF, 32'h14, 32'h1234_5678);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst pre c0_rsp_valid d%0d", d), 32'(c0_rv[d]), 32'd1);
      chk($sformatf("rst c1_req_ready d%0d", d), 32'(c1_rdy[d]), 32'd0);
    end
    step();
    for (int d = 0; d < 2; d++) chk($sformatf("rst drop d%0d", d), 32'(c0_rv[d]), 32'd0);
    rst_n = 1'b1; c0_rsp_rdy = 1'b1;
    set_c1(0, 0, 4'h0, 32'h0, 32'h0);
    set_c0(1, 0, 4'h0, 32'h14, 32'h0); step();
    chk_c0_rsp("rst write blocked", 32'h0BAD_F00D, 0);

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      set_c0($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
      set_c1($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
      c0_rsp_rdy = ($urandom_range(0, 2) != 0);
      c1_rsp_rdy = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dtcm_dual_port.md
Name: dtcm_dual_port

Overview:
- Parametrised successor to the single-port data TCM.
- Arbitrates two independent request channels onto one single-port SRAM array:
  - ch0: core LSU.
  - ch1: DMA/debug bus.
- Each channel has a valid/ready request handshake, byte-enabled writes, and a one-entry response buffer with valid/ready backpressure.
- Misaligned and out-of-range accesses produce an error response.

Parameters:
- DP, 1024, array depth in words.
- DW, 32, data width; multiple of 8 in {32, 64}.
- AW, 32, byte address width.
- ARB_MODE, 0, 0 = fixed priority (ch0 wins); 1 = round-robin.
- Derived locals:
  - BW = DW/8.
  - OFS = log2(BW).
  - IW = clog2(DP).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- c0_req_valid  in  1  ch0 request valid.
- c0_req_ready  out  1  ch0 request accepted this cycle.
- c0_req_wr  in  1  1 = write, 0 = read.
- c0_req_be  in  BW  write byte enables.
- c0_req_addr  in  AW  byte address.
- c0_req_wdata  in  DW  write data.
- c0_rsp_valid  out  1  ch0 response valid.
- c0_rsp_ready  in  1  ch0 response consumed.
- c0_rsp_rdata  out  DW  read data (0 for writes/errors).
- c0_rsp_err  out  1  access error.
- c1_*  same set as c0_*, for ch1.

Behaviour:
- Reset:
  - While rst_n low at a clk edge: all rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, rr_last = 1 (ch0 favoured first).
  - All req_ready = 0 while rst_n low, so no write occurs.
  - Pending responses are dropped.
  - Array contents are not reset.
- Eligibility: eligible_N = !cN_rsp_valid | cN_rsp_ready (the response slot is free or drains this cycle).
- Grant, at most one channel per cycle:
  - Only one channel valid and eligible: it wins.
  - Both valid and eligible, ARB_MODE = 0: ch0 wins.
  - Both valid and eligible, ARB_MODE = 1: the channel != rr_last wins. rr_last updates to the winner on every grant.
- cN_req_ready = rst_n & grantN. It is combinational and may depend on the other channel's valid. It must not feed back into any valid.
- Decode, on the accepted request:
  - idx = addr[OFS+IW-1:OFS].
  - err = (addr[OFS-1:0] != 0) | (addr[AW-1:OFS] >= DP).
- Accepted write, no err:
  - Each byte lane k with be[k] = 1 is written at the clock edge.
  - be = 0 is legal: no array change, normal ack.
- Accepted read, no err: array word at idx is captured into the response buffer at the same edge.
- err = 1: no array access; response carries rsp_err = 1, rsp_rdata = 0.
- Latency:
  - Request accepted at edge N sets cN_rsp_valid at N+1 (registered).
  - The response holds rdata/err stable until the cycle cN_rsp_ready = 1. rsp_valid then clears at the next edge unless a new grant refills it the same edge.
- Every accepted request produces exactly one response, writes included (rdata = 0, err as decoded).
- Back-to-back:
  - A channel with rsp_ready held at 1 sustains 1 request/cycle when uncontended.
  - Write at N followed by read of the same idx at N+1 (either channel) returns the new data.
- Ordering: responses per channel are in request order (depth 1, trivially).
- Backpressure: a channel with a full, unconsumed response is not granted. The other channel may be granted that cycle.

Test Plan:
- Reset, then ch0 writes 0xDEADBEEF @0x10, be = 0xF, then reads @0x10 -> write ack rsp_err = 0; read rsp_valid 1 cycle after accept, rdata = 0xDEADBEEF.
- Partial write, be = 0b0100, wdata = 0x00AA0000 to that word -> read returns 0xDEAABEEF. A be = 0 write leaves it unchanged.
- ch0 reads @0x3 (misaligned) and @DP*4 (out of range) -> both get rsp_err = 1, rdata = 0, no array change.
- Both channels valid every cycle for 6 cycles, rsp_ready = 1:
  - ARB_MODE = 0: ch0 granted all 6 cycles.
  - ARB_MODE = 1: grants alternate ch0, ch1, ch0, ...
- ch1 rsp_ready held 0 for 4 cycles with ch1 valid:
  - ch1 gets one grant; c1_rsp_valid and its data hold stable; c1_req_ready = 0 until rsp_ready rises.
  - ch0 requests proceed meanwhile.
- rst_n low for one cycle while c0_rsp_valid = 1 and a write is pending on ch1:
  - rsp_valid drops next edge; no req_ready during reset.
  - The write target word is unchanged.
